// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - RV32IM instruction-fetch stage with 2-entry fetch queue
//
// Owns the fetch PC, runs one outstanding instruction-memory read at a time
// and buffers up to two fetched instructions. The queue head drives IF/ID.
// EX redirects flush the queue; an access caught mid-flight is completed and
// its response discarded (DROP state) before fetching from the new target.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   imem_read/imem_addr         read request and word address to memory
//   imem_rdata/imem_busywait    memory response; completes when busywait=0
//   branch_taken/branch_target  redirect from EX (target bits [1:0] ignored)
//   id_stall                    ID cannot accept the head this cycle
//   if_valid/if_instr/if_pc/if_pc4  queue head toward ID (zeros when empty)
//   fetch_count/flush_count     push and redirect counters, present only
//                               when IF_PERF_CNT_EN is defined
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_busywait,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DROP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_drop_addr;
  logic [31:0] r_q_pc    [2];
  logic [31:0] r_q_instr [2];
  logic        r_head;
  logic        r_tail;
  logic [1:0]  r_count;

  logic        w_complete;
  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_count_next;
  logic [31:0] w_target;

  // Masking (rather than slicing) keeps every target bit referenced.
  assign w_target   = branch_target & 32'hFFFF_FFFC;
  assign w_complete = (r_state != S_IDLE) && !imem_busywait;
  // A redirect cancels both the push and the pop of its cycle.
  assign w_push     = (r_state == S_FETCH) && w_complete && !branch_taken;
  assign w_pop      = (r_count != 2'd0) && !id_stall && !branch_taken;

  always_comb begin
    w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        // A redirect empties the queue, so it always permits a new fetch.
        if (branch_taken || (r_count < 2'd2)) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        if (branch_taken)    w_state_next = w_complete ? S_FETCH : S_DROP;
        else if (w_complete) w_state_next = (w_count_next < 2'd2) ? S_FETCH : S_IDLE;
      end
      S_DROP: begin
        if (w_complete) w_state_next = S_FETCH;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_drop_addr  <= RESET_PC;
      r_head       <= 1'b0;
      r_tail       <= 1'b0;
      r_count      <= 2'd0;
      r_q_pc[0]    <= 32'h0;
      r_q_pc[1]    <= 32'h0;
      r_q_instr[0] <= 32'h0;
      r_q_instr[1] <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (branch_taken) begin
        r_pc    <= w_target;
        r_head  <= 1'b0;
        r_tail  <= 1'b0;
        r_count <= 2'd0;
        // Remember the in-flight address so the bus stays stable in DROP.
        if ((r_state == S_FETCH) && !w_complete) r_drop_addr <= r_pc;
      end else begin
        if (w_push) begin
          r_q_pc[r_tail]    <= r_pc;
          r_q_instr[r_tail] <= imem_rdata;
          r_tail            <= ~r_tail;
          r_pc              <= r_pc + 32'd4;
        end
        if (w_pop) r_head <= ~r_head;
        r_count <= w_count_next;
      end
    end
  end

  assign imem_read = (r_state != S_IDLE);
  assign imem_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;

  assign if_valid = (r_count != 2'd0);
  assign if_instr = if_valid ? r_q_instr[r_head] : 32'h0;
  assign if_pc    = if_valid ? r_q_pc[r_head] : 32'h0;
  assign if_pc4   = if_valid ? (r_q_pc[r_head] + 32'd4) : 32'h0;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= 32'h0;
      flush_count <= 32'h0;
    end else begin
      if (w_push)       fetch_count <= fetch_count + 32'd1;
      if (branch_taken) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard testbench for if_fetch_unit
module tb_if_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_busywait = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        id_stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  if_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .imem_read(imem_read), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_busywait(imem_busywait),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .id_stall(id_stall),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4)
`ifdef IF_PERF_CNT_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int n_consumed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc = RPC;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference stream: ID must see consecutive word PCs from the last reset or
  // redirect target, each carrying the memory word for that address.
  task automatic topup();
    while (exp_q.size() < 4) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] start);
    exp_q.delete();
    gen_pc = start;
    topup();
  endtask

  // Memory model: random wait states, data = address ^ KEY.
  int          wait_min = 0;
  int          wait_max = 0;
  bit          m_active = 0;
  int          m_left = 0;
  logic [31:0] m_addr = 32'h0;

  always @(posedge clk) begin
    #1;
    if (!reset || !imem_read) m_active = 0;
    else if (m_active) begin
      if (!imem_busywait) m_active = 0;
      else m_left--;
    end
    if (reset && imem_read) begin
      chk("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
      if (!m_active) begin
        m_active = 1;
        m_addr = imem_addr;
        m_left = $urandom_range(wait_max, wait_min);
      end else begin
        chk("addr_stable", imem_addr, m_addr);
      end
    end
    imem_busywait = m_active && (m_left > 0);
    imem_rdata = m_addr ^ KEY;
  end

  // Monitor: a head consumed by ID is popped from the scoreboard and compared.
  bit prev_br = 0;
  always @(negedge clk) begin
    if (reset) begin
      if (prev_br) chk("valid_after_redirect", {31'h0, if_valid}, 32'h0);
      if (!if_valid) begin
        chk("bubble_instr", if_instr, 32'h0);
        chk("bubble_pc", if_pc, 32'h0);
        chk("bubble_pc4", if_pc4, 32'h0);
      end else if (!id_stall && !branch_taken) begin
        logic [31:0] e;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard_empty: got pc %h expected none", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("if_pc", if_pc, e);
          chk("if_instr", if_instr, e ^ KEY);
          chk("if_pc4", if_pc4, e + 32'd4);
          n_consumed++;
        end
      end
      prev_br = branch_taken;
    end else begin
      prev_br = 0;
    end
  end

  task automatic cyc(input bit br, input logic [31:0] tgt, input bit st);
    @(posedge clk);
    #2;
    branch_taken = br;
    branch_target = tgt;
    id_stall = st;
    if (br) restart(tgt & 32'hFFFF_FFFC);
    else topup();
  endtask

  task automatic redirect_now(input logic [31:0] tgt);
    branch_taken = 1'b1;
    branch_target = tgt;
    restart(tgt & 32'hFFFF_FFFC);
  endtask

  task automatic reset_now();
    reset = 1'b0;
    branch_taken = 1'b0;
    id_stall = 1'b0;
    restart(RPC);
    #1;
    chk("rst_imem_read", {31'h0, imem_read}, 32'h0);
    chk("rst_imem_addr", imem_addr, RPC);
    chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_pc4", if_pc4, 32'h0);
  endtask

  task automatic do_reset(input bit st);
    @(posedge clk);
    #2;
    reset_now();
    @(posedge clk);
    #2;
    reset = 1'b1;
    id_stall = st;
    topup();
  endtask

  initial begin
    int base;
    bit hit;
    logic [31:0] old;

    // Reset and straight-line zero-wait fetch.
    do_reset(0);
    base = n_consumed;
    repeat (20) cyc(0, 32'h0, 0);
    n_tests++;
    if (n_consumed - base < 16) begin
      n_fail++;
      $display("FAIL throughput: got %0d expected >=16", n_consumed - base);
    end

    // Backpressure from reset: two completions then idle.
    do_reset(1);
    repeat (6) cyc(0, 32'h0, 1);
    chk("bp_imem_read", {31'h0, imem_read}, 32'h0);
    chk("bp_valid", {31'h0, if_valid}, 32'h1);
    chk("bp_if_pc", if_pc, RPC);
    cyc(0, 32'h0, 0);
    cyc(0, 32'h0, 0);
    chk("bp_second_valid", {31'h0, if_valid}, 32'h1);
    chk("bp_second_pc", if_pc, RPC + 32'd4);
    repeat (5) cyc(0, 32'h0, 0);

    // Redirect during the first busy cycle of a 3-wait access.
    wait_min = 3; wait_max = 3;
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      cyc(0, 32'h0, 0);
      if (imem_read && imem_busywait && m_left == 3) begin
        hit = 1;
        old = imem_addr;
        redirect_now(32'h0000_2003);
      end
    end
    chk("drop_found_busy", {31'h0, hit}, 32'h1);
    cyc(0, 32'h0, 0);
    chk("drop_read_held", {31'h0, imem_read}, 32'h1);
    chk("drop_addr_held", imem_addr, old);
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      cyc(0, 32'h0, 0);
      if (if_valid) hit = 1;
    end
    chk("drop_first_valid", {31'h0, hit}, 32'h1);
    chk("drop_first_pc", if_pc, 32'h0000_2000);

    // Redirect coinciding with a completion and a pop.
    wait_min = 0; wait_max = 0;
    repeat (4) cyc(0, 32'h0, 0);
    redirect_now(32'h0000_3000);
    cyc(0, 32'h0, 0);
    chk("coinc_valid", {31'h0, if_valid}, 32'h0);
    chk("coinc_addr", imem_addr, 32'h0000_3000);
    repeat (6) cyc(0, 32'h0, 0);

    // PC wrap-around.
    cyc(1, 32'hFFFF_FFF9, 0);
    hit = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 32'h0, 0);
      if (imem_read && imem_addr == 32'h0) hit = 1;
    end
    chk("wrap_addr_zero", {31'h0, hit}, 32'h1);

    // Randomized traffic.
    wait_min = 0; wait_max = 3;
    base = n_consumed;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15, 0)) : $urandom;
      cyc($urandom_range(19, 0) == 0, t, $urandom_range(9, 0) < 3);
    end
    n_tests++;
    if (n_consumed - base < 300) begin
      n_fail++;
      $display("FAIL random_progress: got %0d expected >=300", n_consumed - base);
    end

`ifdef IF_PERF_CNT_EN
    wait_min = 0; wait_max = 0;
    do_reset(1);
    repeat (6) cyc(0, 32'h0, 1);
    cyc(1, 32'h0000_4000, 1);
    cyc(1, 32'h0000_5000, 1);
    repeat (6) cyc(0, 32'h0, 1);
    cyc(0, 32'h0, 0);
    repeat (6) cyc(0, 32'h0, 1);
    chk("perf_fetch_count", fetch_count, 32'd5);
    chk("perf_flush_count", flush_count, 32'd2);
    cyc(0, 32'h0, 0);
`endif

    // Reset asserted in the middle of a busy access.
    wait_min = 3; wait_max = 3;
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      cyc(0, 32'h0, 0);
      if (imem_read && imem_busywait) hit = 1;
    end
    chk("midrst_busy", {31'h0, hit}, 32'h1);
    reset_now();
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
